// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 VGA timing generator.
//   - Horizontal/vertical timing (pixels / lines) and their totals
//   - Coordinate widths for the x (column) and y (row) outputs
//   - Default sync polarity (0 = active-low)
package vga_timing_pkg;

    localparam int unsigned HActive = 640;
    localparam int unsigned HFp     = 16;
    localparam int unsigned HSync   = 96;
    localparam int unsigned HBp     = 48;
    localparam int unsigned HTotal  = HActive + HFp + HSync + HBp;

    localparam int unsigned VActive = 480;
    localparam int unsigned VFp     = 10;
    localparam int unsigned VSync   = 2;
    localparam int unsigned VBp     = 33;
    localparam int unsigned VTotal  = VActive + VFp + VSync + VBp;

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;

    localparam bit SyncPol = 1'b0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen.
//   pix_en      : one-clock pixel strobe
//   x / y       : 1-based active coordinates, 0 during blanking
//   active      : inside the visible area
//   hsync/vsync : sync pins, asserted at the configured polarity
//   frame_start : high for one pixel period at raster position (0,0)
// master = timing generator, slave = downstream image generator.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic          pix_en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          frame_start;

    modport master (
        output pix_en,
        output x,
        output y,
        output active,
        output hsync,
        output vsync,
        output frame_start
    );

    modport slave (
        input pix_en,
        input x,
        input y,
        input active,
        input hsync,
        input vsync,
        input frame_start
    );

endinterface

// File: rtl/vga_timing_gen_pix_strobe_div.sv
// Pixel-rate strobe divider.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset
//   pix_en_o : registered strobe, high for one clock every ClkDiv clocks
// The strobe register samples the terminal count, so the first strobe after
// reset release appears in the ClkDiv-th clock.
module pix_strobe_div #(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o
);

    localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            pix_en_q, pix_en_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == CntLast) ? '0 : div_cnt_q + CntW'(1);
        pix_en_d  = (div_cnt_q == CntLast);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
        end
    end

    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default) with integrated pixel
// strobe.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   vga     : raster outputs (pix_en, x, y, active, hsync, vsync, frame_start)
// Counters advance on the pixel strobe; all outputs are registered from the
// decode of the advanced counter values, so a position is presented one clock
// after the strobe that advanced to it and holds for CLK_DIV clocks.
// Build option VGA_TIMING_SYNC_DELAY_EN: hsync, vsync and frame_start get one
// extra pixel-strobe register stage so they lag x/y/active by one pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = HActive,
    parameter int unsigned H_FP     = HFp,
    parameter int unsigned H_SYNC   = HSync,
    parameter int unsigned H_BP     = HBp,
    parameter int unsigned V_ACTIVE = VActive,
    parameter int unsigned V_FP     = VFp,
    parameter int unsigned V_SYNC   = VSync,
    parameter int unsigned V_BP     = VBp,
    parameter bit          SYNC_POL = SyncPol
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] HLast      = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] HAct       = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HSyncStart = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HSyncEnd   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [YW-1:0] VLast      = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] VAct       = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VSyncStart = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VSyncEnd   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic pix_en;

    pix_strobe_div #(
        .ClkDiv (CLK_DIV)
    ) u_pix_strobe_div (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .pix_en_o (pix_en)
    );

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          active_q, active_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;

    // Raster counters: v advances only when h wraps.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == HLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + YW'(1);
            end else begin
                h_cnt_d = h_cnt_q + XW'(1);
            end
        end
    end

    // Decode on the advanced values so outputs line up with the new position.
    always_comb begin
        active_d      = (h_cnt_d < HAct) && (v_cnt_d < VAct);
        x_d           = active_d ? h_cnt_d + XW'(1) : '0;
        y_d           = active_d ? v_cnt_d + YW'(1) : '0;
        hsync_d       = ((h_cnt_d >= HSyncStart) && (h_cnt_d <= HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_cnt_d >= VSyncStart) && (v_cnt_d <= VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    // Reset parks the counters at the last position so the first strobe lands
    // on (0,0).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_cnt_q       <= HLast;
            v_cnt_q       <= VLast;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_SYNC_DELAY_EN
    // One-pixel lag to match a registered RGB stage downstream.
    logic hsync_dly_q, vsync_dly_q, frame_start_dly_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hsync_dly_q       <= ~SYNC_POL;
            vsync_dly_q       <= ~SYNC_POL;
            frame_start_dly_q <= 1'b0;
        end else if (pix_en) begin
            hsync_dly_q       <= hsync_q;
            vsync_dly_q       <= vsync_q;
            frame_start_dly_q <= frame_start_q;
        end
    end

    assign vga.hsync       = hsync_dly_q;
    assign vga.vsync       = vsync_dly_q;
    assign vga.frame_start = frame_start_dly_q;
`else
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_start = frame_start_q;
`endif

    assign vga.pix_en = pix_en;
    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.active = active_q;

endmodule
